// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: exception codes, register addresses, field positions
// and the exception-controller state encoding.
package cp0_pkg;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   // Status and Cause field positions
   localparam int ST_IE     = 0;
   localparam int ST_EXL    = 1;
   localparam int ST_IM_LO  = 8;
   localparam int ST_BEV    = 22;
   localparam int CA_EXC_LO = 2;
   localparam int CA_IP_LO  = 8;
   localparam int CA_BD     = 31;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_REDIRECT
   } cp0_state_e;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare register and the IP7
// match flag that is cleared by any Compare write.
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int COUNT_DIV = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              count_we,
   input  logic              compare_we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] count_o,
   output logic [DATA_W-1:0] compare_o,
   output logic              ip7_o
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [DIV_W-1:0]  div_q, div_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] compare_q, compare_d;
   logic              ip7_q, ip7_d;
   logic              tick;

   always_comb begin
      tick      = (div_q == DIV_W'(COUNT_DIV - 1));
      div_d     = tick ? '0 : div_q + DIV_W'(1);
      count_d   = count_q;
      compare_d = compare_q;
      ip7_d     = ip7_q;
      // A software Count write takes precedence over the prescaled increment
      if (count_we) begin
         count_d = wdata;
      end else if (tick) begin
         count_d = count_q + DATA_W'(1);
         if (count_d == compare_q) ip7_d = 1'b1;
      end
      if (compare_we) begin
         compare_d = wdata;
         ip7_d     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
         ip7_q     <= 1'b0;
      end else begin
         div_q     <= div_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         ip7_q     <= ip7_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ip7_o     = ip7_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file and precise exception/interrupt controller: prioritises
// stage exceptions, updates EPC/Cause/Status and sequences flush + PC redirect.
//
// state    | meaning
// S_IDLE   | accepting exceptions, interrupts and ERET
// S_FLUSH  | one-cycle kill of all in-flight stages
// S_REDIRECT | redirect_valid held until FETCH accepts redirect_pc
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                N_HW_INT   = 6,
   parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int                COUNT_DIV  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_HW_INT-1:0] hw_int,
   input  logic                if_adel,
   input  logic [DATA_W-1:0]   if_pc,
   input  logic                if_bd,
   input  logic                id_ri,
   input  logic                id_sys,
   input  logic                id_bp,
   input  logic [DATA_W-1:0]   id_pc,
   input  logic                id_bd,
   input  logic                exe_ov,
   input  logic [DATA_W-1:0]   exe_pc,
   input  logic                exe_bd,
   input  logic                mem_adel,
   input  logic                mem_ades,
   input  logic [DATA_W-1:0]   mem_pc,
   input  logic                mem_bd,
   input  logic [DATA_W-1:0]   mem_bva,
   input  logic                mem_valid,
   input  logic                eret,
   input  logic                cp0_we,
   input  logic [4:0]          cp0_addr,
   input  logic [2:0]          cp0_sel,
   input  logic [DATA_W-1:0]   cp0_wdata,
   output logic [DATA_W-1:0]   cp0_rdata,
   output logic                flush,
   output logic                redirect_valid,
   output logic [DATA_W-1:0]   redirect_pc,
   input  logic                redirect_ready,
   output logic                busy,
   output logic [DATA_W-1:0]   status_o,
   output logic [DATA_W-1:0]   cause_o,
   output logic [DATA_W-1:0]   epc_o
);

   cp0_state_e        state_q, state_d;
   logic [7:0]        im_q, im_d;
   logic              exl_q, exl_d;
   logic              ie_q, ie_d;
   logic [1:0]        ip_sw_q, ip_sw_d;
   logic [N_HW_INT-1:0] ip_hw_q;
   logic [4:0]        exc_code_q, exc_code_d;
   logic              bd_q, bd_d;
   logic [DATA_W-1:0] epc_q, epc_d;
   logic [DATA_W-1:0] badvaddr_q, badvaddr_d;
   logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;

   logic [DATA_W-1:0] count_w, compare_w;
   logic              timer_ip7;
   logic [7:0]        ip;
   logic [DATA_W-1:0] status_v, cause_v;
   logic              sel0, we_status, we_cause, we_epc;
   logic              int_pend;
   logic              ev_take, ev_bd, ev_bva_we;
   logic [4:0]        ev_code;
   logic [DATA_W-1:0] ev_pc, ev_bva;

   assign sel0      = (cp0_sel == 3'd0);
   assign we_status = cp0_we && sel0 && (cp0_addr == REG_STATUS);
   assign we_cause  = cp0_we && sel0 && (cp0_addr == REG_CAUSE);
   assign we_epc    = cp0_we && sel0 && (cp0_addr == REG_EPC);

   cp0_timer #(
      .DATA_W    (DATA_W),
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_we   (cp0_we && sel0 && (cp0_addr == REG_COUNT)),
      .compare_we (cp0_we && sel0 && (cp0_addr == REG_COMPARE)),
      .wdata      (cp0_wdata),
      .count_o    (count_w),
      .compare_o  (compare_w),
      .ip7_o      (timer_ip7)
   );

   // With six hardware lines the last one shares IP7 with the timer
   always_comb begin
      ip      = '0;
      ip[1:0] = ip_sw_q;
      for (int i = 0; i < N_HW_INT; i++) ip[2+i] = ip_hw_q[i];
      ip[7]   = ip[7] | timer_ip7;

      status_v                     = '0;
      status_v[ST_BEV]             = 1'b1;
      status_v[ST_IM_LO +: 8]      = im_q;
      status_v[ST_EXL]             = exl_q;
      status_v[ST_IE]              = ie_q;

      cause_v                      = '0;
      cause_v[CA_BD]               = bd_q;
      cause_v[CA_IP_LO +: 8]       = ip;
      cause_v[CA_EXC_LO +: 5]      = exc_code_q;
   end

   assign int_pend = (|(ip & im_q)) && ie_q && !exl_q && mem_valid;

   always_comb begin
      ev_take   = 1'b1;
      ev_code   = EXC_INT;
      ev_pc     = mem_pc;
      ev_bd     = 1'b0;
      ev_bva_we = 1'b0;
      ev_bva    = mem_bva;
      if (mem_adel) begin
         ev_code = EXC_ADEL; ev_bd = mem_bd; ev_bva_we = 1'b1;
      end else if (mem_ades) begin
         ev_code = EXC_ADES; ev_bd = mem_bd; ev_bva_we = 1'b1;
      end else if (exe_ov) begin
         ev_code = EXC_OV; ev_pc = exe_pc; ev_bd = exe_bd;
      end else if (id_ri) begin
         ev_code = EXC_RI; ev_pc = id_pc; ev_bd = id_bd;
      end else if (id_sys) begin
         ev_code = EXC_SYS; ev_pc = id_pc; ev_bd = id_bd;
      end else if (id_bp) begin
         ev_code = EXC_BP; ev_pc = id_pc; ev_bd = id_bd;
      end else if (if_adel) begin
         ev_code = EXC_ADEL; ev_pc = if_pc; ev_bd = if_bd;
         ev_bva_we = 1'b1; ev_bva = if_pc;
      end else if (!int_pend) begin
         ev_take = 1'b0;
      end
   end

   always_comb begin
      state_d       = state_q;
      im_d          = im_q;
      exl_d         = exl_q;
      ie_d          = ie_q;
      ip_sw_d       = ip_sw_q;
      exc_code_d    = exc_code_q;
      bd_d          = bd_q;
      epc_d         = epc_q;
      badvaddr_d    = badvaddr_q;
      redirect_pc_d = redirect_pc_q;

      if (we_status) begin
         im_d  = cp0_wdata[ST_IM_LO +: 8];
         exl_d = cp0_wdata[ST_EXL];
         ie_d  = cp0_wdata[ST_IE];
      end
      if (we_cause) ip_sw_d = cp0_wdata[CA_IP_LO +: 2];
      if (we_epc)   epc_d   = cp0_wdata;

      // Event updates are applied after MTC0 so they win on shared fields
      unique case (state_q)
         S_IDLE: begin
            if (ev_take) begin
               exc_code_d    = ev_code;
               bd_d          = ev_bd;
               epc_d         = ev_bd ? ev_pc - DATA_W'(4) : ev_pc;
               exl_d         = 1'b1;
               if (ev_bva_we) badvaddr_d = ev_bva;
               redirect_pc_d = EXC_VECTOR;
               state_d       = S_FLUSH;
            end else if (eret) begin
               exl_d         = 1'b0;
               redirect_pc_d = epc_q;
               state_d       = S_FLUSH;
            end
         end
         S_FLUSH:    state_d = S_REDIRECT;
         S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         im_q          <= '0;
         exl_q         <= 1'b0;
         ie_q          <= 1'b0;
         ip_sw_q       <= '0;
         ip_hw_q       <= '0;
         exc_code_q    <= '0;
         bd_q          <= 1'b0;
         epc_q         <= '0;
         badvaddr_q    <= '0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         im_q          <= im_d;
         exl_q         <= exl_d;
         ie_q          <= ie_d;
         ip_sw_q       <= ip_sw_d;
         ip_hw_q       <= hw_int;
         exc_code_q    <= exc_code_d;
         bd_q          <= bd_d;
         epc_q         <= epc_d;
         badvaddr_q    <= badvaddr_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   always_comb begin
      cp0_rdata = '0;
      if (sel0) begin
         unique case (cp0_addr)
            REG_BADVADDR: cp0_rdata = badvaddr_q;
            REG_COUNT:    cp0_rdata = count_w;
            REG_COMPARE:  cp0_rdata = compare_w;
            REG_STATUS:   cp0_rdata = status_v;
            REG_CAUSE:    cp0_rdata = cause_v;
            REG_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
         endcase
      end
   end

   assign flush          = (state_q == S_FLUSH);
   assign redirect_valid = (state_q == S_REDIRECT);
   assign redirect_pc    = redirect_pc_q;
   assign busy           = (state_q != S_IDLE);
   assign status_o       = status_v;
   assign cause_o        = cause_v;
   assign epc_o          = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: reset, priority, BD/BadVAddr, interrupts,
// timer match, ERET and handshake behaviour.
module tb_cp0_exc_ctrl;

   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  hw_int;
   logic        if_adel, if_bd, id_ri, id_sys, id_bp, id_bd, exe_ov, exe_bd;
   logic        mem_adel, mem_ades, mem_bd, mem_valid, eret;
   logic [31:0] if_pc, id_pc, exe_pc, mem_pc, mem_bva;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [2:0]  cp0_sel;
   logic [31:0] cp0_wdata, cp0_rdata;
   logic        flush, redirect_valid, redirect_ready, busy;
   logic [31:0] redirect_pc, status_o, cause_o, epc_o;

   int tests_run = 0;
   int tests_failed = 0;

   cp0_exc_ctrl #(
      .DATA_W(32), .N_HW_INT(6), .EXC_VECTOR(VEC), .COUNT_DIV(2)
   ) dut (
      .clk(clk), .reset(reset), .hw_int(hw_int),
      .if_adel(if_adel), .if_pc(if_pc), .if_bd(if_bd),
      .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_pc(id_pc), .id_bd(id_bd),
      .exe_ov(exe_ov), .exe_pc(exe_pc), .exe_bd(exe_bd),
      .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_pc(mem_pc), .mem_bd(mem_bd),
      .mem_bva(mem_bva), .mem_valid(mem_valid), .eret(eret),
      .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_sel(cp0_sel), .cp0_wdata(cp0_wdata),
      .cp0_rdata(cp0_rdata), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .busy(busy),
      .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      cp0_addr = a;
      cp0_sel  = 3'd0;
      #1;
      v = cp0_rdata;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cp0_we = 1'b1; cp0_addr = a; cp0_sel = 3'd0; cp0_wdata = d;
      cyc();
      cp0_we = 1'b0;
   endtask

   task automatic finish_redirect();
      int n = 0;
      while (!redirect_valid && n < 20) begin
         cyc();
         n++;
      end
      tests_run++;
      if (!redirect_valid) begin
         tests_failed++;
         $display("FAIL redirect_timeout got=%0b exp=1", redirect_valid);
      end
      redirect_ready = 1'b1;
      cyc();
      redirect_ready = 1'b0;
   endtask

   task automatic clear_inputs();
      hw_int = '0; if_adel = 0; if_bd = 0; id_ri = 0; id_sys = 0; id_bp = 0; id_bd = 0;
      exe_ov = 0; exe_bd = 0; mem_adel = 0; mem_ades = 0; mem_bd = 0; mem_valid = 0;
      eret = 0; if_pc = '0; id_pc = '0; exe_pc = '0; mem_pc = '0; mem_bva = '0;
      cp0_we = 0; cp0_addr = '0; cp0_sel = '0; cp0_wdata = '0; redirect_ready = 0;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      tests_run++;
      if (status_o !== 32'h0040_0000) begin tests_failed++; $display("FAIL reset_status got=%h exp=%h", status_o, 32'h0040_0000); end
      tests_run++;
      if (cause_o !== 32'h0) begin tests_failed++; $display("FAIL reset_cause got=%h exp=0", cause_o); end
      tests_run++;
      if (epc_o !== 32'h0) begin tests_failed++; $display("FAIL reset_epc got=%h exp=0", epc_o); end
      tests_run++;
      if (flush !== 1'b0 || redirect_valid !== 1'b0 || busy !== 1'b0 || redirect_pc !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_ctrl got=%b%b%b pc=%h exp=000 pc=0", flush, redirect_valid, busy, redirect_pc);
      end
      rd(5'd12, v);
      tests_run++;
      if (v !== 32'h0040_0000) begin tests_failed++; $display("FAIL reset_rd_status got=%h exp=%h", v, 32'h0040_0000); end
      rd(5'd9, v);
      tests_run++;
      if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_count got=%h exp=0", v); end
   endtask

   task automatic test_timer();
      logic [31:0] v;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      wr(5'd11, 32'd5);              // edge 1
      for (int i = 2; i <= 9; i++) cyc();
      rd(5'd9, v);
      tests_run++;
      if (v !== 32'd4 || cause_o[15] !== 1'b0) begin
         tests_failed++;
         $display("FAIL timer_pre count=%0d ip7=%b exp count=4 ip7=0", v, cause_o[15]);
      end
      cyc();                          // edge 10
      rd(5'd9, v);
      tests_run++;
      if (v !== 32'd5 || cause_o[15] !== 1'b1) begin
         tests_failed++;
         $display("FAIL timer_match count=%0d ip7=%b exp count=5 ip7=1", v, cause_o[15]);
      end
      wr(5'd11, 32'd20);
      tests_run++;
      if (cause_o[15] !== 1'b0) begin tests_failed++; $display("FAIL timer_clear ip7 got=%b exp=0", cause_o[15]); end
      rd(5'd11, v);
      tests_run++;
      if (v !== 32'd20) begin tests_failed++; $display("FAIL timer_compare got=%0d exp=20", v); end
   endtask

   task automatic test_exc_priority();
      exe_ov = 1; exe_pc = 32'h100; exe_bd = 0;
      id_sys = 1; id_pc = 32'h200;
      cyc();                          // edge t
      exe_ov = 0; id_sys = 0;
      tests_run++;
      if (flush !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL prio_flush got=%b exp=1", flush); end
      tests_run++;
      if (cause_o[6:2] !== 5'd12) begin tests_failed++; $display("FAIL prio_code got=%0d exp=12", cause_o[6:2]); end
      tests_run++;
      if (epc_o !== 32'h100 || status_o[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL prio_epc_exl epc=%h exl=%b exp epc=100 exl=1", epc_o, status_o[1]);
      end
      id_ri = 1; id_pc = 32'h999;     // arrives while busy, must be ignored
      for (int k = 0; k < 2; k++) begin
         cyc();
         tests_run++;
         if (redirect_valid !== 1'b1 || redirect_pc !== VEC || flush !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_hold%0d valid=%b pc=%h exp valid=1 pc=%h", k, redirect_valid, redirect_pc, VEC);
         end
      end
      id_ri = 0;
      redirect_ready = 1;
      cyc();
      redirect_ready = 0;
      tests_run++;
      if (redirect_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL prio_release valid=%b busy=%b exp 0 0", redirect_valid, busy); end
      tests_run++;
      if (epc_o !== 32'h100 || cause_o[6:2] !== 5'd12) begin
         tests_failed++;
         $display("FAIL prio_ignored epc=%h code=%0d exp epc=100 code=12", epc_o, cause_o[6:2]);
      end
   endtask

   task automatic test_stage_codes();
      logic [31:0] v;
      mem_adel = 1; mem_pc = 32'h204; mem_bd = 1; mem_bva = 32'h1003;
      cyc();
      mem_adel = 0; mem_bd = 0;
      rd(5'd8, v);
      tests_run++;
      if (epc_o !== 32'h200 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd4 || v !== 32'h1003) begin
         tests_failed++;
         $display("FAIL mem_adel epc=%h bd=%b code=%0d bva=%h exp 200 1 4 1003", epc_o, cause_o[31], cause_o[6:2], v);
      end
      finish_redirect();

      if_adel = 1; if_pc = 32'h604; if_bd = 0;
      cyc();
      if_adel = 0;
      rd(5'd8, v);
      tests_run++;
      if (epc_o !== 32'h604 || cause_o[31] !== 1'b0 || cause_o[6:2] !== 5'd4 || v !== 32'h604) begin
         tests_failed++;
         $display("FAIL if_adel epc=%h bd=%b code=%0d bva=%h exp 604 0 4 604", epc_o, cause_o[31], cause_o[6:2], v);
      end
      finish_redirect();

      id_ri = 1; id_bp = 1; id_pc = 32'h708; id_bd = 1;
      cyc();
      id_ri = 0; id_bp = 0; id_bd = 0;
      rd(5'd8, v);
      tests_run++;
      if (epc_o !== 32'h704 || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd10 || v !== 32'h604) begin
         tests_failed++;
         $display("FAIL id_ri epc=%h bd=%b code=%0d bva=%h exp 704 1 10 604", epc_o, cause_o[31], cause_o[6:2], v);
      end
      finish_redirect();
   endtask

   task automatic test_interrupt();
      wr(5'd12, 32'h0000_0401);
      hw_int[0] = 1;
      cyc();
      tests_run++;
      if (cause_o[10] !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL int_ip2 ip2=%b busy=%b exp 1 0", cause_o[10], busy);
      end
      mem_valid = 1; mem_pc = 32'h300; mem_bd = 0;
      cyc();
      mem_valid = 0;
      tests_run++;
      if (flush !== 1'b1 || cause_o[6:2] !== 5'd0 || epc_o !== 32'h300 || status_o[1] !== 1'b1) begin
         tests_failed++;
         $display("FAIL int_take flush=%b code=%0d epc=%h exl=%b exp 1 0 300 1", flush, cause_o[6:2], epc_o, status_o[1]);
      end
      finish_redirect();
      mem_valid = 1; mem_pc = 32'h380;
      cyc();
      mem_valid = 0;
      tests_run++;
      if (flush !== 1'b0 || busy !== 1'b0 || epc_o !== 32'h300) begin
         tests_failed++;
         $display("FAIL int_exl_mask flush=%b busy=%b epc=%h exp 0 0 300", flush, busy, epc_o);
      end
      hw_int = '0;
      cyc();
   endtask

   task automatic test_eret();
      eret = 1;
      cyc();
      eret = 0;
      tests_run++;
      if (flush !== 1'b1 || status_o[1] !== 1'b0) begin
         tests_failed++;
         $display("FAIL eret_flush flush=%b exl=%b exp 1 0", flush, status_o[1]);
      end
      cyc();
      tests_run++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin
         tests_failed++;
         $display("FAIL eret_pc valid=%b pc=%h exp 1 300", redirect_valid, redirect_pc);
      end
      finish_redirect();
   endtask

   task automatic test_eret_vs_exc();
      logic [31:0] v;
      eret = 1; mem_ades = 1; mem_pc = 32'h400; mem_bd = 0; mem_bva = 32'h2002;
      cyc();
      eret = 0; mem_ades = 0;
      rd(5'd8, v);
      tests_run++;
      if (cause_o[6:2] !== 5'd5 || status_o[1] !== 1'b1 || epc_o !== 32'h400 || v !== 32'h2002) begin
         tests_failed++;
         $display("FAIL eret_vs_exc code=%0d exl=%b epc=%h bva=%h exp 5 1 400 2002", cause_o[6:2], status_o[1], epc_o, v);
      end
      cyc();
      tests_run++;
      if (redirect_pc !== VEC) begin tests_failed++; $display("FAIL eret_vs_exc_pc got=%h exp=%h", redirect_pc, VEC); end
      finish_redirect();
   endtask

   task automatic test_mtc0_overlap();
      logic [31:0] v;
      cp0_we = 1; cp0_addr = 5'd12; cp0_sel = 0; cp0_wdata = 32'hFFFF_AB01;
      id_bp = 1; id_pc = 32'h500; id_bd = 0;
      cyc();
      cp0_we = 0; id_bp = 0;
      tests_run++;
      if (status_o !== 32'h0040_AB03 || cause_o[6:2] !== 5'd9 || epc_o !== 32'h500) begin
         tests_failed++;
         $display("FAIL mtc0_overlap status=%h code=%0d epc=%h exp 0040ab03 9 500", status_o, cause_o[6:2], epc_o);
      end
      finish_redirect();
      wr(5'd13, 32'hFFFF_FFFF);
      tests_run++;
      if (cause_o[9:8] !== 2'b11 || cause_o[6:2] !== 5'd9 || cause_o[31] !== 1'b0) begin
         tests_failed++;
         $display("FAIL cause_wmask ip=%b code=%0d bd=%b exp 11 9 0", cause_o[9:8], cause_o[6:2], cause_o[31]);
      end
      wr(5'd8, 32'hDEAD_BEEF);
      rd(5'd8, v);
      tests_run++;
      if (v !== 32'h2002) begin tests_failed++; $display("FAIL badvaddr_ro got=%h exp=2002", v); end
      wr(5'd5, 32'h0000_00FF);
      rd(5'd5, v);
      tests_run++;
      if (v !== 32'h0) begin tests_failed++; $display("FAIL unmapped_rd got=%h exp=0", v); end
      cp0_sel = 3'd1;
      cp0_addr = 5'd14;
      #1;
      tests_run++;
      if (cp0_rdata !== 32'h0) begin tests_failed++; $display("FAIL sel1_rd got=%h exp=0", cp0_rdata); end
      cp0_sel = 3'd0;
   endtask

   task automatic test_reset_midhandshake();
      exe_ov = 1; exe_pc = 32'h800;
      cyc();
      exe_ov = 0;
      cyc();
      tests_run++;
      if (redirect_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre valid=%b exp=1", redirect_valid); end
      reset = 1;
      cyc();
      reset = 0;
      tests_run++;
      if (redirect_valid !== 1'b0 || busy !== 1'b0 || redirect_pc !== 32'h0 || status_o !== 32'h0040_0000) begin
         tests_failed++;
         $display("FAIL mid_reset valid=%b busy=%b pc=%h status=%h exp 0 0 0 00400000", redirect_valid, busy, redirect_pc, status_o);
      end
      cyc();
      tests_run++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_after valid=%b flush=%b exp 0 0", redirect_valid, flush);
      end
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      #1;
      test_reset();
      test_timer();
      test_exc_priority();
      test_stage_codes();
      test_interrupt();
      test_eret();
      test_eret_vs_exc();
      test_mtc0_overlap();
      test_reset_midhandshake();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Parametrised CP0 register file plus precise-exception/interrupt controller for the 5-stage MIPS pipeline.
- Collects per-stage exception requests and prioritises them so that exactly one event is taken at a time.
- Updates BadVAddr, Status, Cause, EPC, Count and Compare; drives a pipeline flush and a PC redirect handshake to FETCH.
- Adds N hardware interrupt lines, a Count/Compare timer, ERET and branch-delay-slot handling.

Parameters:
- DATA_W, 32, register/datapath width.
- N_HW_INT, 6, number of hardware interrupt inputs (1..6), mapped to Cause.IP[2+N_HW_INT-1:2].
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception and interrupt.
- COUNT_DIV, 2, Count increments once every COUNT_DIV cycles (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- hw_int  in  N_HW_INT  level-sensitive external interrupts
- if_adel  in  1  fetch address error; if_pc/if_bd  in  DATA_W/1
- id_ri, id_sys, id_bp  in  1 each  reserved-instr/syscall/break; id_pc/id_bd  in  DATA_W/1
- exe_ov  in  1  overflow; exe_pc/exe_bd  in  DATA_W/1
- mem_adel, mem_ades  in  1 each  load/store address error; mem_pc/mem_bd  in  DATA_W/1; mem_bva  in  DATA_W
- mem_valid  in  1  MEM holds a valid instruction (interrupt boundary)
- eret  in  1  ERET committing in MEM
- cp0_we  in  1; cp0_addr  in  5; cp0_sel  in  3; cp0_wdata  in  DATA_W  MTC0 write (WB)
- cp0_rdata  out  DATA_W  combinational MFC0 read for cp0_addr/cp0_sel
- flush  out  1  one-cycle kill of all in-flight stages
- redirect_valid  out  1; redirect_pc  out  DATA_W; redirect_ready  in  1  PC redirect handshake
- busy  out  1  high whenever state≠IDLE
- status_o, cause_o, epc_o  out  DATA_W  register mirrors

Behaviour:
- Reset (sync): Status=32'h0040_0000 (BEV=1, EXL=0, IE=0, IM=0), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, divider=0, state=IDLE, flush=0, redirect_valid=0, redirect_pc=0. Reset mid-handshake returns to IDLE with no redirect.
- Registers (addr, sel 0): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Other addresses read 0 and ignore writes. Writable fields: Status IM[15:8], EXL[1], IE[0]; Cause IP[9:8] only. All other bits read-only.
- Priority, oldest first: MEM AdEL > MEM AdES > EXE Ov > ID RI > ID Sys > ID Bp > IF AdEL > interrupt.
- Interrupt pending when (Cause.IP & Status.IM)≠0, Status.IE=1, Status.EXL=0 and mem_valid=1. EPC for an interrupt is mem_pc.
- ExcCodes: Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12.
- Taking an event in IDLE (same cycle): Cause.ExcCode=code; Cause.BD=stage_bd; EPC=stage_pc, or stage_pc−4 when stage_bd=1; Status.EXL=1. BadVAddr=mem_bva for MEM AdEL/AdES, if_pc for IF AdEL, otherwise unchanged.
- FSM:
  - IDLE -(event)-> FLUSH. FLUSH asserts flush for exactly one cycle, then goes to REDIRECT.
  - REDIRECT holds redirect_valid=1 with redirect_pc stable until redirect_ready=1, then returns to IDLE.
  - ERET in IDLE with no exception: redirect_pc=EPC, Status.EXL←0, enters FLUSH.
  - Latency: event at cycle t → flush at t+1 → redirect_valid from t+2.
- Requests and eret arriving outside IDLE are ignored; the flush kills them.
- Exception and eret in the same cycle: the exception wins.
- Timer: Count increments every COUNT_DIV cycles and wraps at 2^DATA_W−1→0. Count==Compare (after an increment) sets Cause.IP7; a write to Compare clears IP7. Hardware IP bits track hw_int every cycle.
- An MTC0 write in the same cycle an event is taken: the event's updates win on overlapping fields (EXL, ExcCode, BD, EPC, BadVAddr); non-overlapping written fields still update.

Decomposition:
- Shared package cp0_pkg: ExcCode constants, CP0 register addresses, Status/Cause bit positions, FSM state enum (IDLE, FLUSH, REDIRECT).
- One sub-module, cp0_timer: Count, divider, Compare and the IP7 match logic.

Test Plan:
- Reset, then read Status/Cause/EPC → 32'h0040_0000/0/0; flush=0, redirect_valid=0.
- exe_ov=1, exe_pc=0x100, exe_bd=0 together with id_sys=1 → ExcCode=12, EPC=0x100, EXL=1; flush at t+1; redirect_pc=0xBFC00380 held until redirect_ready is asserted two cycles later.
- mem_adel=1, mem_pc=0x204, mem_bd=1, mem_bva=0x1003 → EPC=0x200, Cause.BD=1, BadVAddr=0x1003, ExcCode=4.
- Status=0x0000_0401, hw_int[0]=1, mem_valid=1, mem_pc=0x300 → interrupt taken, ExcCode=0, EPC=0x300. Repeat with EXL=1 → no event taken.
- Compare=5, COUNT_DIV=2 → IP7 set at cycle 10 after Count reset; write Compare=20 → IP7 clears.
- eret with EPC=0x300 → flush, redirect_pc=0x300, EXL=0. eret concurrent with mem_ades → the exception is taken, EXL stays 1.
